mul_by_x4_plus_x: RTL and testbench

- Sequential word-serial multiplier over GF(2)[x]. Computes p(x) = a(x)·(x^4 + x), carry-less, with no modular reduction.
- Used in the Toom-K interpolation/evaluation path as the forward counterpart of the exact divider by (x^4 + x). It regenerates the dividend from a quotient and is used to cross-check divider results.
- Operand is consumed W bits per cycle, with a start/busy/done handshake.

---
 rtl/mul_by_x4_plus_x.sv | 110 +++++++++++
 tb/tb_mul_by_x4_plus_x.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_by_x4_plus_x.sv
// mul_by_x4_plus_x
// Word-serial carry-less multiplier over GF(2)[x]: p(x) = a(x) * (x^4 + x).
// There is no modular reduction. This is the forward partner of the exact
// divider by (x^4 + x), and it rebuilds a dividend from a quotient.
//
// The operand is consumed W bits per clock, so a job takes NW = ceil(N/W) edges.
//
// Ports:
//   clk    in   1     rising-edge clock
//   rst    in   1     synchronous active-high reset; overrides everything
//   start  in   1     request a job; only sampled while busy = 0
//   a      in   N     operand; bit i is the coefficient of x^i
//   p      out  N+4   product; bit i is the coefficient of x^i
//   busy   out  1     a job is in progress
//   done   out  1     one-cycle pulse on the edge that completes p
//
// state  | meaning
// S_IDLE | waiting for start; p holds the last result
// S_RUN  | folding chunk k of the latched operand into p each edge

module mul_by_x4_plus_x #(
    parameter int N = 4460,
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    output logic [N+3:0]   p,
    output logic           busy,
    output logic           done
);

    localparam int NW = (N + W - 1) / W;
    localparam int AW = NW * W;
    localparam int PW = N + 4;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   a_q, a_d;
    logic [PW-1:0]   p_q, p_d;
    logic [KW-1:0]   k_q, k_d;
    logic            done_q, done_d;

    logic [W-1:0]    chunk;
    logic [W+3:0]    term;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        k_d     = k_q;
        done_d  = 1'b0;

        chunk = a_q[int'(k_q) * W +: W];
        term  = ({4'b0000, chunk} << 1) ^ ({4'b0000, chunk} << 4);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Zero padding of the operand is what keeps the partial
                    // last chunk from writing anything above bit N+3.
                    a_d     = AW'(a);
                    p_d     = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Adjacent chunks overlap by 4 bits. The shift is done at
                // product width, so anything past bit N+3 falls off.
                p_d = p_q ^ (PW'(term) << (int'(k_q) * W));
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_mul_by_x4_plus_x.sv
// Testbench for mul_by_x4_plus_x (N=4460, W=64).
// The stimulus process issues jobs and pushes the expected products into a
// scoreboard queue. The monitor process pops one entry and compares it on every
// done pulse, and it also checks latency and pulse width.

module tb_mul_by_x4_plus_x;

    localparam int N  = 4460;
    localparam int W  = 64;
    localparam int NW = 70;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N+3:0]   p;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    mul_by_x4_plus_x #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .p     (p),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [N+3:0] ep;
        logic [N-1:0] av;
        bit           inv;
    } sb_t;

    sb_t sb[$];

    int n_vec   = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int run_len = 0;
    bit prev_done = 1'b0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Returns the index of the first differing bit, or -1 if the values match.
    function automatic int first_diff(input logic [N+3:0] x, input logic [N+3:0] y);
        for (int i = 0; i < N + 4; i++)
            if (x[i] !== y[i]) return i;
        return -1;
    endfunction

    // Clears p[0] and shifts right by 1 to get q = a*(x^3+1).
    // Exact division by (x^3+1) then gives r[i] = q[i] ^ r[i-3].
    function automatic logic [N-1:0] div_x3p1(input logic [N+3:0] pp);
        logic [N+2:0] q;
        logic [N-1:0] r;
        q = pp[N+3:1];
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (i >= 3) r[i] = q[i] ^ r[i-3];
            else        r[i] = q[i];
        end
        return r;
    endfunction

    function automatic logic [N+3:0] model(input logic [N-1:0] av);
        logic [N+3:0] ext;
        ext = {4'b0000, av};
        return (ext << 1) ^ (ext << 4);
    endfunction

    // Monitor.
    sb_t mon_e;
    int  mon_d;
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("done_width", !prev_done, longint'(prev_done), 0);
            check("latency", run_len == NW, run_len, NW);
            check("busy_at_done", !busy, longint'(busy), 0);
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b0, 1, 0);
            end else begin
                mon_e = sb.pop_front();
                mon_d = first_diff(p, mon_e.ep);
                check("product_first_bad_bit", mon_d < 0, mon_d, -1);
                if (mon_e.inv)
                    check("inverse_divide", div_x3p1(p) === mon_e.av, 1, 0);
            end
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else begin
            run_len = 0;
        end
        prev_done = done;
    end

    // Called at a negedge while busy = 0; the next posedge is the accepting edge.
    task automatic issue(input logic [N-1:0] av, input logic [N+3:0] ep, input bit push, input bit inv);
        sb_t e;
        a     = av;
        start = 1'b1;
        if (push) begin
            e.ep  = ep;
            e.av  = av;
            e.inv = inv;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 1'b0, 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d done pulses", n_done);
        $fatal(1, "watchdog");
    end

    logic [N-1:0]   av;
    logic [N+3:0]   ep;
    int             dn;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_p", p === '0, first_diff(p, '0), -1);
        check("reset_busy", busy === 1'b0, longint'(busy), 0);
        check("reset_done", done === 1'b0, longint'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // a = 1 gives x^4 + x = 0x12. After the job, p must stay put.
        av = '0; av[0] = 1'b1;
        ep = '0; ep[7:0] = 8'h12;
        issue(av, ep, 1'b1, 1'b0);
        wait_done();
        repeat (5) @(negedge clk);
        check("p_hold_after_done", first_diff(p, ep) < 0, first_diff(p, ep), -1);
        check("idle_after_done", busy === 1'b0, longint'(busy), 0);

        // Directed table, run back to back.
        for (int v = 0; v < 7; v++) begin
            av = '0;
            ep = '0;
            case (v)
                0: begin av[3:0] = 4'h9; ep[7:0] = 8'h82; end          // (x^3+1) -> x^7+x
                1: begin av[3:0] = 4'h5; ep[7:0] = 8'h5A; end          // (x^2+1) -> x^6+x^4+x^3+x
                2: begin av[63] = 1'b1; ep[64] = 1'b1; ep[67] = 1'b1; end
                3: begin av[N-1] = 1'b1; ep[N] = 1'b1; ep[N+3] = 1'b1; end
                4: begin av[67:60] = 8'hFF; ep[71:60] = 12'hE0E; end    // straddles chunk 0/1
                5: begin av = '1; ep[3:1] = 3'b111; ep[N+3:N+1] = 3'b111; end
                default: begin end                                      // zero operand
            endcase
            issue(av, ep, 1'b1, 1'b0);
            wait_done();
        end

        // Starts while busy must be ignored, and a change to a has no effect.
        @(negedge clk);
        av = '0; av[1:0] = 2'b11;
        ep = '0; ep[7:0] = 8'h36;                                       // (x+1)(x^4+x)
        dn = n_done;
        issue(av, ep, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        a = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        a = '0; a[100] = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("single_done_pulse", n_done == dn + 1, n_done - dn, 1);

        // Reset partway through a job abandons it.
        av = '0; av[10:0] = 11'h5A5;
        issue(av, '0, 1'b0, 1'b0);
        repeat (39) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_p", p === '0, first_diff(p, '0), -1);
        check("abort_busy", busy === 1'b0, longint'(busy), 0);
        check("abort_done", done === 1'b0, longint'(done), 0);
        rst = 1'b0;
        dn = n_done;
        repeat (100) @(negedge clk);
        check("no_done_after_abort", n_done == dn, n_done - dn, 0);
        av = '0; av[2] = 1'b1;
        ep = '0; ep[3] = 1'b1; ep[6] = 1'b1;
        issue(av, ep, 1'b1, 1'b0);
        wait_done();

        // Random operands back to back; also checked by exact division.
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < N; i++) av[i] = 1'($urandom_range(0, 1));
            issue(av, model(av), 1'b1, 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
